// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: playback state encodings,
// display timing constants and digit geometry.
package game_pkg;

    typedef enum logic [1:0] {
        PB_IDLE = 2'd0,
        PB_ON   = 2'd1,
        PB_GAP  = 2'd2,
        PB_DONE = 2'd3
    } pb_state_t;

    localparam int CLK_HZ      = 50000000;
    localparam int T_DIGIT_ON  = CLK_HZ / 2;   // 0.5 s digit on-time
    localparam int T_DIGIT_GAP = CLK_HZ / 4;   // 0.25 s blank between digits

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    // Saturate a requested sequence length to the number of digit slots.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_playback_ctrl_if.sv
// Request/display bundle between the game FSM (master) and the playback
// controller (slave).
interface seq_playback_ctrl_if #(
    parameter int MAX_DIGITS = 8,
    parameter int IDX_W      = 3
);
    logic                                   start_play;
    logic                                   abort;
    logic [game_pkg::DIGIT_W*MAX_DIGITS-1:0] answer_seq;
    logic [3:0]                             seq_len;
    logic [game_pkg::DIGIT_W-1:0]           disp_digit;
    logic                                   disp_valid;
    logic [IDX_W-1:0]                       digit_idx;
    logic                                   busy;
    logic                                   play_done;

    modport master (
        output start_play, abort, answer_seq, seq_len,
        input  disp_digit, disp_valid, digit_idx, busy, play_done
    );

    modport slave (
        input  start_play, abort, answer_seq, seq_len,
        output disp_digit, disp_valid, digit_idx, busy, play_done
    );
endinterface

// File: rtl/seq_playback_ctrl_phase_timer.sv
// Loadable down-counter that stops at zero; expire_o flags count == 0.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);
    logic [W-1:0] count_q, count_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/seq_playback_ctrl.sv
// Plays a latched digit sequence on the display: each digit is shown for
// ON_CYCLES, separated by GAP_CYCLES of blank, then play_done is held.
module seq_playback_ctrl
    import game_pkg::*;
#(
    parameter int ON_CYCLES  = game_pkg::T_DIGIT_ON,
    parameter int GAP_CYCLES = game_pkg::T_DIGIT_GAP,
    parameter int MAX_DIGITS = game_pkg::MAX_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    seq_playback_ctrl_if.slave  pb
);
    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int LEN_W   = $clog2(MAX_DIGITS + 1);
    localparam int SEQ_W   = DIGIT_W * MAX_DIGITS;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    pb_state_t          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic               timer_load;
    logic [CNT_W-1:0]   timer_val;
    logic               timer_expire;
    logic [LEN_W-1:0]   start_len;
    logic               last_digit;

    logic [DIGIT_W-1:0] digits [MAX_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIGITS; gi++) begin : g_digit
            assign digits[gi] = seq_q[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    assign start_len  = LEN_W'(clamp_len(int'(pb.seq_len), MAX_DIGITS));
    assign last_digit = (int'(idx_q) == int'(len_q) - 1);

    phase_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .expire_o   (timer_expire)
    );

    // Next-state logic; abort overrides everything including a same-cycle start.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        len_d      = len_q;
        timer_load = 1'b0;
        timer_val  = '0;
        if (pb.abort) begin
            state_d    = PB_IDLE;
            idx_d      = '0;
            timer_load = 1'b1;
        end else begin
            case (state_q)
                PB_IDLE, PB_DONE: begin
                    if (pb.start_play) begin
                        seq_d = pb.answer_seq;
                        len_d = start_len;
                        idx_d = '0;
                        if (start_len == '0) begin
                            state_d = PB_DONE;
                        end else begin
                            state_d    = PB_ON;
                            timer_load = 1'b1;
                            timer_val  = ON_LOAD;
                        end
                    end
                end
                PB_ON: begin
                    if (timer_expire) begin
                        if (last_digit) begin
                            state_d = PB_DONE;
                        end else begin
                            state_d    = PB_GAP;
                            timer_load = 1'b1;
                            timer_val  = GAP_LOAD;
                        end
                    end
                end
                PB_GAP: begin
                    if (timer_expire) begin
                        state_d    = PB_ON;
                        idx_d      = idx_q + IDX_W'(1);
                        timer_load = 1'b1;
                        timer_val  = ON_LOAD;
                    end
                end
                default: state_d = PB_IDLE;
            endcase
        end
    end

    // State and playback context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PB_IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        pb.disp_valid = 1'b0;
        pb.disp_digit = '0;
        pb.busy       = 1'b0;
        pb.play_done  = 1'b0;
        pb.digit_idx  = idx_q;
        case (state_q)
            PB_ON: begin
                pb.disp_valid = 1'b1;
                pb.disp_digit = digits[idx_q];
                pb.busy       = 1'b1;
            end
            PB_GAP:  pb.busy      = 1'b1;
            PB_DONE: pb.play_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Bench for seq_playback_ctrl with ON_CYCLES=4, GAP_CYCLES=2.
module tb_seq_playback_ctrl;
    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int MAXD = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_playback_ctrl_if #(.MAX_DIGITS(MAXD), .IDX_W(3)) pb ();

    seq_playback_ctrl #(
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .MAX_DIGITS (MAXD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pb  (pb)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic [31:0] seq;
        logic [3:0]  len;
        logic        valid;
        logic [3:0]  digit;
        logic [2:0]  idx;
        logic        busy;
        logic        done;
    } vec_t;

    typedef struct {
        logic [3:0] d;
        logic [2:0] i;
    } dexp_t;

    vec_t  vecs[$];
    vec_t  exp_q[$];
    dexp_t dig_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Drive a start request and queue the digits the display should show.
    task automatic start_seq(input logic [31:0] seq, input logic [3:0] len);
        int n;
        dexp_t e;
        n = (int'(len) > MAXD) ? MAXD : int'(len);
        pb.answer_seq = seq;
        pb.seq_len    = len;
        pb.start_play = 1'b1;
        for (int i = 0; i < n; i++) begin
            e.d = seq[4*i +: 4];
            e.i = 3'(i);
            dig_q.push_back(e);
        end
        step(1);
        cyc = 1;
        pb.start_play = 1'b0;
    endtask

    // Wait for play_done with a cycle budget; check the cycle it rose on.
    task automatic wait_done(input string name, input int exp_cycle);
        while (!pb.play_done && cyc < 300) step(1);
        if (!pb.play_done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: play_done still 0 after %0d cycles, required 1", name, cyc);
        end else begin
            chk(name, 32'(cyc), 32'(exp_cycle));
            $display("%s: play_done at cycle %0d", name, cyc);
        end
        chk({name, "_digits_left"}, 32'(dig_q.size()), 32'd0);
    endtask

    task automatic chk_outputs(input string name, input logic v, input logic [3:0] d,
                               input logic [2:0] i, input logic b, input logic pd);
        chk({name, "_valid"}, 32'(pb.disp_valid), 32'(v));
        chk({name, "_digit"}, 32'(pb.disp_digit), 32'(d));
        chk({name, "_idx"},   32'(pb.digit_idx),  32'(i));
        chk({name, "_busy"},  32'(pb.busy),       32'(b));
        chk({name, "_done"},  32'(pb.play_done),  32'(pd));
    endtask

    // Digit monitor: each new ON phase pops one expected digit; each ON phase lasts ON cycles.
    initial begin : monitor
        bit    prev_valid;
        int    run_len;
        dexp_t de;
        prev_valid = 1'b0;
        run_len    = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_valid = 1'b0;
                run_len    = 0;
            end else begin
                if (pb.disp_valid && !prev_valid) begin
                    if (dig_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_digit: got digit %0h idx %0d, required no digit",
                                 pb.disp_digit, pb.digit_idx);
                    end else begin
                        de = dig_q.pop_front();
                        chk("digit", 32'(pb.disp_digit), 32'(de.d));
                        chk("digit_idx", 32'(pb.digit_idx), 32'(de.i));
                        $display("digit %0h at idx %0d", pb.disp_digit, pb.digit_idx);
                    end
                end
                if (!pb.disp_valid && prev_valid) chk("on_len", 32'(run_len), 32'(ON));
                run_len    = pb.disp_valid ? run_len + 1 : 0;
                prev_valid = pb.disp_valid;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t v;
        vec_t e;
        int c, p, n;

        pb.start_play = 1'b0;
        pb.abort      = 1'b0;
        pb.answer_seq = '0;
        pb.seq_len    = '0;
        rst           = 1'b1;

        // ---- Vector table -------------------------------------------------
        // Entry k drives inputs before edge k; expectations describe cycle k+1.
        // Playback of 3,2,1 -> digits 1,2,3: ON cycles 1-4,7-10,13-16, gaps 5-6,11-12.
        for (int k = 0; k < 18; k++) begin
            c = k + 1;
            v.start = (k == 0);
            v.abort = 1'b0;
            v.seq   = 32'h0000_0321;
            v.len   = 4'd3;
            if (c <= 16) begin
                p = (c - 1) % (ON + GAP);
                n = (c - 1) / (ON + GAP);
                v.valid = (p < ON);
                v.digit = (p < ON) ? 4'(n + 1) : 4'd0;
                v.idx   = 3'(n);
                v.busy  = 1'b1;
                v.done  = 1'b0;
            end else begin
                v.valid = 1'b0; v.digit = 4'd0; v.idx = 3'd2; v.busy = 1'b0; v.done = 1'b1;
            end
            vecs.push_back(v);
        end
        // Abort from DONE clears everything.
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0321, 4'd3, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0});
        // Zero-length start: done on the next cycle, nothing shown, never busy.
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0321, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0321, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0321, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0});

        step(2);
        chk_outputs("reset", 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            pb.start_play = vecs[k].start;
            pb.abort      = vecs[k].abort;
            pb.answer_seq = vecs[k].seq;
            pb.seq_len    = vecs[k].len;
            exp_q.push_back(vecs[k]);
            step(1);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_valid", k), 32'(pb.disp_valid), 32'(e.valid));
            chk($sformatf("vec%0d_digit", k), 32'(pb.disp_digit), 32'(e.digit));
            chk($sformatf("vec%0d_idx", k),   32'(pb.digit_idx),  32'(e.idx));
            chk($sformatf("vec%0d_busy", k),  32'(pb.busy),       32'(e.busy));
            chk($sformatf("vec%0d_done", k),  32'(pb.play_done),  32'(e.done));
            $display("vec %0d: valid=%0b digit=%0h idx=%0d busy=%0b done=%0b",
                     k, pb.disp_valid, pb.disp_digit, pb.digit_idx, pb.busy, pb.play_done);
        end
        pb.start_play = 1'b0;
        pb.abort      = 1'b0;

        // ---- Length saturates at 8 digits ---------------------------------
        mon_en = 1'b1;
        start_seq(32'h8765_4321, 4'd12);
        wait_done("len12", 8*ON + 7*GAP + 1);

        // ---- Start during GAP is ignored; start in DONE restarts ----------
        start_seq(32'h0000_0054, 4'd2);
        step(4);                               // cycle 5: first gap
        chk("gap_state_busy", 32'(pb.busy), 32'd1);
        pb.answer_seq = 32'h0000_0099;
        pb.seq_len    = 4'd1;
        pb.start_play = 1'b1;
        step(1);
        pb.start_play = 1'b0;
        chk("gap_start_valid", 32'(pb.disp_valid), 32'd0);
        chk("gap_start_idx", 32'(pb.digit_idx), 32'd0);
        wait_done("gap_start", 2*ON + GAP + 1);

        start_seq(32'h0000_0007, 4'd1);
        chk_outputs("restart", 1'b1, 4'h7, 3'd0, 1'b1, 1'b0);
        wait_done("restart", ON + 1);

        // ---- abort + start together in ON --------------------------------
        mon_en = 1'b0;
        start_seq(32'h0000_0021, 4'd2);
        step(1);
        pb.abort      = 1'b1;
        pb.start_play = 1'b1;
        pb.answer_seq = 32'h0000_0055;
        pb.seq_len    = 4'd2;
        step(1);
        pb.abort      = 1'b0;
        pb.start_play = 1'b0;
        chk_outputs("abort_start", 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        step(3);
        chk_outputs("abort_idle", 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);

        // ---- reset mid-ON -------------------------------------------------
        start_seq(32'h0000_0021, 4'd2);
        step(1);
        rst = 1'b1;
        step(1);
        chk_outputs("rst_mid_on", 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        dig_q.delete();
        step(1);

        // ---- inputs changed after acceptance have no effect ---------------
        mon_en = 1'b1;
        start_seq(32'h0000_0ABC, 4'd3);
        step(2);                               // cycle 3
        pb.answer_seq = 32'hFFFF_FFFF;
        pb.seq_len    = 4'd1;
        wait_done("latched_seq", 3*ON + 2*GAP + 1);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_playback_ctrl.md
Name: seq_playback_ctrl

Overview:
- Sequences playback of the generated answer sequence on the 7-segment/LED display, digit by digit, with fixed on-time and inter-digit gap.
- Sits between the game FSM and the display datapath. Consumes the game FSM's start_play pulse and answer_seq. Returns a level play_done that the game FSM qualifies with !start_play.
- Also supplies the per-digit index and valid strobe used by the buzzer/LED drivers.

Parameters:
- ON_CYCLES, 25000000, cycles each digit is shown (0.5 s at 50 MHz); legal range >= 1.
- GAP_CYCLES, 12500000, blank cycles between consecutive digits (0.25 s); legal range >= 1.
- MAX_DIGITS, 8, digit slots in answer_seq (4 bits each; answer_seq width = 4*MAX_DIGITS).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-high reset
- start_play  in  1  single-cycle request to begin playback
- abort  in  1  cancel playback immediately
- answer_seq  in  32  packed digits; digit i = answer_seq[4i+3:4i]
- seq_len  in  4  number of digits to play, 0..15
- disp_digit  out  4  digit value currently shown
- disp_valid  out  1  high while a digit is shown (ON phase)
- digit_idx  out  3  index of the digit being shown or last shown
- busy  out  1  high in ON or GAP
- play_done  out  1  level; high from playback completion until the next accepted start or abort

Behaviour:
- Reset is synchronous and active-high on clk: when rst is sampled high, state=IDLE and all outputs are 0, the internal counter is 0, and the latched sequence is 0. Reset mid-playback aborts on the same edge.
- States: IDLE, ON, GAP, DONE (registered, Moore outputs).
- Start acceptance:
  - start_play is accepted only in IDLE or DONE. It is ignored in ON or GAP.
  - On the accepting edge: latch answer_seq into seq_q, latch len_q = min(seq_len, MAX_DIGITS), clear play_done.
  - If len_q == 0, go to DONE; play_done is high on the next cycle with no digit shown.
  - Otherwise go to ON with idx=0, counter=ON_CYCLES-1.
- ON:
  - disp_valid=1, disp_digit=seq_q[4*idx+3:4*idx], digit_idx=idx, busy=1.
  - Counter decrements each cycle. At counter==0:
    - if idx == len_q-1, go to DONE;
    - else go to GAP with counter=GAP_CYCLES-1.
- GAP:
  - disp_valid=0, disp_digit=0, busy=1.
  - At counter==0, go to ON with idx+1 and counter=ON_CYCLES-1.
- DONE: play_done=1, busy=0, disp_valid=0. Remains in DONE until an accepted start_play or abort.
- Latency: if start is accepted at edge 0, disp_valid is high for cycles 1..ON_CYCLES. play_done rises at cycle len*ON_CYCLES + (len-1)*GAP_CYCLES + 1.
- abort:
  - In any state, goes to IDLE next edge with play_done=0 and outputs cleared.
  - abort has priority over start_play sampled on the same edge.
- Input stability: answer_seq and seq_len changes after acceptance have no effect on the current playback.
- No wrap: idx never exceeds len_q-1. Counters are sized to clog2(max(ON_CYCLES, GAP_CYCLES)).

Decomposition:
- Shared package game_pkg holds:
  - state encodings (PB_IDLE/PB_ON/PB_GAP/PB_DONE);
  - timing constants CLK_HZ=50000000, T_DIGIT_ON, T_DIGIT_GAP;
  - DIGIT_W=4 and MAX_DIGITS=8, reused by the game FSM and the sequence generator.
- One sub-module is natural: phase_timer. It is a loadable down-counter with load, load_val, and an expire flag (count==0). It is reused later for the input-timeout timer.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2 in bench):
- answer_seq=32'h0000_0321, seq_len=3, start at cycle 0 -> disp_digit 1,2,3 each valid for cycles 1-4, 7-10, 13-16; disp_valid=0 for cycles 5-6 and 11-12; play_done rises at cycle 17 and stays high.
- seq_len=0 with start -> play_done=1 at cycle 1, disp_valid never asserted, busy stays 0.
- seq_len=12, answer_seq=32'h8765_4321 -> exactly 8 digits 1..8 played, then play_done.
- start_play pulsed again during GAP -> ignored, sequence completes unchanged; a start in DONE -> play_done drops next cycle and playback restarts from idx 0.
- abort and start_play asserted together in ON -> IDLE, play_done=0, no restart; rst=1 mid-ON -> all outputs 0 next edge.
- answer_seq changed at cycle 3 of playback -> displayed digits still match the value latched at start.
